ro_puf_vote: RTL

- Parametrised ring-oscillator PUF response engine for NUM_RO external configurable ROs; successor to the fixed 9-RO, 8-bit PUF front end.
- Measures each RO over a programmable clock window, then forms NUM_RO-1 adjacent-pair comparison bits.
- Repeats the full sweep VOTES times and majority-votes each bit, which suppresses marginal-pair noise.
- Presents the response plus the captured challenge on a valid/ready handshake, feeding the hash and display stage.

---
 rtl/puf_pkg.sv | 20 ++
 rtl/ro_edge_counter.sv | 43 ++++
 rtl/ro_puf_vote.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF voting engine.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_STORE,
    ST_COMPARE,
    ST_DONE
  } puf_state_t;

  localparam int SETTLE_CYCLES = 3;

  // Width needed to hold a vote tally of 0..votes.
  function automatic int vote_w(input int votes);
    return $clog2(votes + 1);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output, detects rising edges and counts them
// with saturation. clr holds the count at zero while the synchroniser refills.
module ro_edge_counter #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ro,
  output logic [CNT_W-1:0] cnt
);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rise;

  assign rise = sync2_reg && !prev_reg;
  assign cnt  = cnt_reg;

  // The synchroniser keeps sampling during clr so stale samples of the
  // previously selected RO are gone before counting starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= ro;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (clr) begin
        cnt_reg <= '0;
      end else if (en && rise && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_vote.sv
// RO PUF response engine: sweeps NUM_RO oscillators VOTES times and majority-votes
// each adjacent-pair bit. Define PUF_STABILITY_MASK_EN to add the 'unstable' output.
module ro_puf_vote
  import puf_pkg::*;
#(
  parameter int NUM_RO = 9,
  parameter int CNT_W  = 25,
  parameter int WINDOW = 1_000_000,
  parameter int VOTES  = 5,
  parameter int CHAL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_in,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              start,
  input  logic              abort,
  output logic              ro_en,
  output logic [CHAL_W-1:0] ro_chal,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [NUM_RO-2:0] response,
  output logic [CHAL_W-1:0] resp_challenge
`ifdef PUF_STABILITY_MASK_EN
  ,
  output logic [NUM_RO-2:0] unstable
`endif
);

  localparam int VOTE_W = vote_w(VOTES);
  localparam int IDX_W  = $clog2(NUM_RO);
  localparam int TMR_W  = $clog2(WINDOW + SETTLE_CYCLES) + 1;
  localparam int NPAIR  = NUM_RO - 1;

  puf_state_t        state_reg;
  puf_state_t        state_next;
  logic [TMR_W-1:0]  timer_reg;
  logic [IDX_W-1:0]  ro_idx_reg;
  logic [VOTE_W-1:0] round_reg;
  logic [CNT_W-1:0]  cnt_reg  [NUM_RO];
  logic [VOTE_W-1:0] vote_reg [NPAIR];
  logic [VOTE_W-1:0] vote_next[NPAIR];
  logic [NPAIR-1:0]  pair_gt;
  logic [NPAIR-1:0]  resp_next;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ro_sel;
  logic              timer_zero;
  logic              last_ro;
  logic              last_round;
  logic              abort_hit;

  assign ro_sel     = ro_in[ro_idx_reg];
  assign timer_zero = (timer_reg == '0);
  assign last_ro    = (ro_idx_reg == IDX_W'(NUM_RO - 1));
  assign last_round = (round_reg == VOTE_W'(VOTES - 1));
  assign abort_hit  = abort && (state_reg != ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign ro_en      = busy && (state_reg != ST_DONE);

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk(clk),
    .rst(rst),
    .clr(state_reg == ST_SETTLE),
    .en (state_reg == ST_MEASURE),
    .ro (ro_sel),
    .cnt(edge_cnt)
  );

  // Per-pair comparison and the tally it produces if this is the COMPARE cycle.
  for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
    assign pair_gt[gi]   = (cnt_reg[gi] > cnt_reg[gi+1]);
    assign vote_next[gi] = vote_reg[gi] + VOTE_W'(pair_gt[gi]);
    assign resp_next[gi] = (vote_next[gi] > VOTE_W'(VOTES / 2));
  end

`ifdef PUF_STABILITY_MASK_EN
  logic [NPAIR-1:0] unstable_next;
  for (genvar gi = 0; gi < NPAIR; gi++) begin : g_unstable
    assign unstable_next[gi] = (vote_next[gi] != '0) && (vote_next[gi] != VOTE_W'(VOTES));
  end
`endif

  always_comb begin
    state_next = state_reg;
    if (abort_hit) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (start && !abort) state_next = ST_SETTLE;
        ST_SETTLE:  if (timer_zero) state_next = ST_MEASURE;
        ST_MEASURE: if (timer_zero) state_next = ST_STORE;
        ST_STORE:   state_next = last_ro ? ST_COMPARE : ST_SETTLE;
        ST_COMPARE: state_next = last_round ? ST_DONE : ST_SETTLE;
        ST_DONE:    if (resp_ready) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      ro_idx_reg     <= '0;
      round_reg      <= '0;
      ro_chal        <= '0;
      resp_valid     <= 1'b0;
      response       <= '0;
      resp_challenge <= '0;
`ifdef PUF_STABILITY_MASK_EN
      unstable       <= '0;
`endif
      for (int i = 0; i < NUM_RO; i++) cnt_reg[i] <= '0;
      for (int i = 0; i < NPAIR; i++) vote_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (abort_hit) begin
        resp_valid <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (state_next == ST_SETTLE) begin
              ro_chal    <= challenge;
              ro_idx_reg <= '0;
              round_reg  <= '0;
              timer_reg  <= TMR_W'(SETTLE_CYCLES - 1);
              for (int i = 0; i < NPAIR; i++) vote_reg[i] <= '0;
            end
          end
          ST_SETTLE: begin
            timer_reg <= timer_zero ? TMR_W'(WINDOW - 1) : timer_reg - TMR_W'(1);
          end
          ST_MEASURE: begin
            if (!timer_zero) timer_reg <= timer_reg - TMR_W'(1);
          end
          ST_STORE: begin
            cnt_reg[ro_idx_reg] <= edge_cnt;
            timer_reg           <= TMR_W'(SETTLE_CYCLES - 1);
            if (!last_ro) ro_idx_reg <= ro_idx_reg + IDX_W'(1);
          end
          ST_COMPARE: begin
            for (int i = 0; i < NPAIR; i++) vote_reg[i] <= vote_next[i];
            round_reg  <= round_reg + VOTE_W'(1);
            ro_idx_reg <= '0;
            timer_reg  <= TMR_W'(SETTLE_CYCLES - 1);
            // Final round: the result is registered on the way into DONE.
            if (last_round) begin
              response       <= resp_next;
              resp_challenge <= ro_chal;
              resp_valid     <= 1'b1;
`ifdef PUF_STABILITY_MASK_EN
              unstable       <= unstable_next;
`endif
            end
          end
          ST_DONE: begin
            if (resp_ready) resp_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
